mux_rr_arbiter: RTL

Parametrised successor to the N-bit 2:1 mux. It selects one of N W-bit channels using valid/ready handshakes and round-robin arbitration, then registers the selected word on a single output channel. It sits between multiple requesters and one shared consumer, for example register-file write-back or memory-port sharing in the Simple RISC datapath. Throughput is one word per cycle.

---
 rtl/mux_rr_arbiter_pkg.sv | 15 +
 rtl/mux_rr_arbiter_if.sv | 36 +++
 rtl/mux_rr_arbiter_rr_pick.sv | 53 +++++
 rtl/mux_rr_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared sizing helpers for the round-robin mux arbiter
// Package mux_arb_pkg: select-index width and pointer reset value.
package mux_arb_pkg;

  // Width of a channel index; at least one bit so N=1 still has a port.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pointer reset value: last channel, so the first scan starts at channel 0.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - N-channel request bus plus single output channel
// Signals:
//   in_data  N*W  channel i at [i*W +: W]
//   in_valid N    per-channel request
//   in_ready N    per-channel accept (one-hot or zero)
//   out_data W    registered selected word
//   out_valid 1   out_data holds a word
//   out_ready 1   consumer accepts
//   out_sel  SW   channel that supplied out_data
// Modports: slave = arbiter side, master = requesters/consumer side.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
);
  localparam int SW = sel_w(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational grant picker
// Ports: req[N] requests, ptr last granted index (MUX_ARB_RR_EN only),
//        gnt[N] one-hot grant, idx binary grant index.
// MUX_ARB_RR_EN defined: first request scanning upward from ptr+1, wrapping.
// MUX_ARB_RR_EN undefined: lowest set request wins.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
`ifdef MUX_ARB_RR_EN
  input  logic [SW-1:0] ptr,
`endif
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic found;

`ifdef MUX_ARB_RR_EN
  // Request vector doubled so a wrapping scan becomes a linear one: bits at
  // or below ptr are masked off, and the first surviving bit is the winner.
  logic [2*N-1:0] dbl;
  assign dbl = {req, req};

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i] && (i > int'(ptr))) begin
        found = 1'b1;
        idx   = SW'(i % N);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end
`else
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = SW'(i);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - N-to-1 valid/ready mux with registered output
// Ports: clk, rst_n (async, active-low), bus (mux_rr_arbiter_if.slave).
// Macro MUX_ARB_RR_EN selects round-robin (defined) or fixed priority.
// One word per cycle; output register refills in the same cycle it drains.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_rr_arbiter_if.slave     bus
);

  localparam int SW = sel_w(N);

  logic          accept;
  logic [N-1:0]  gnt;
  logic [SW-1:0] idx;
  logic          transfer;
  logic [W-1:0]  sel_data;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q;
  logic [SW-1:0] out_sel_q;

`ifdef MUX_ARB_RR_EN
  logic [SW-1:0] ptr;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );
`else
  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req (bus.in_valid),
    .gnt (gnt),
    .idx (idx)
  );
`endif

  // Room in the output register when empty or being drained this cycle.
  assign accept       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = accept ? gnt : '0;
  assign transfer     = |(bus.in_valid & bus.in_ready);
  assign sel_data     = bus.in_data[int'(idx)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
`ifdef MUX_ARB_RR_EN
      ptr         <= SW'(ptr_reset(N));
`endif
    end else if (transfer) begin
      out_data_q  <= sel_data;
      out_sel_q   <= idx;
      out_valid_q <= 1'b1;
`ifdef MUX_ARB_RR_EN
      ptr         <= idx;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;

endmodule
